// File: rtl/div_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_issue_pkg : opcodes, handshake levels, FSM encoding   rev 1.0    |
// +----------------------------------------------------------------------+
package div_issue_pkg;

   localparam int REG_BUS        = 32;
   localparam int DOUBLE_REG_BUS = 64;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   localparam logic DIV_START        = 1'b1;
   localparam logic DIV_STOP         = 1'b0;
   localparam logic DIV_RESULT_READY = 1'b1;

   localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      DIV_ISS_IDLE = 2'd0,
      DIV_ISS_BUSY = 2'd1,
      DIV_ISS_DONE = 2'd2
   } div_iss_state_t;

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_issue : EX-stage divider requester with one-shot HI/LO write  rev 1.0 |
// +----------------------------------------------------------------------+
module div_issue
   import div_issue_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                aluop_i,
   input  logic [REG_BUS-1:0]        reg1_i,
   input  logic [REG_BUS-1:0]        reg2_i,
   input  logic                      flush_i,
   input  logic                      hold_i,
   output logic                      div_start_o,
   output logic                      div_signed_o,
   output logic [REG_BUS-1:0]        div_opdata1_o,
   output logic [REG_BUS-1:0]        div_opdata2_o,
   output logic                      div_annul_o,
   input  logic [DOUBLE_REG_BUS-1:0] div_result_i,
   input  logic                      div_ready_i,
   output logic                      stallreq_o,
   output logic                      whilo_o,
   output logic [REG_BUS-1:0]        hi_o,
   output logic [REG_BUS-1:0]        lo_o
);

   div_iss_state_t            state;
   logic [REG_BUS-1:0]        opdata1;
   logic [REG_BUS-1:0]        opdata2;
   logic                      signed_flag;
   logic [DOUBLE_REG_BUS-1:0] result;
   logic                      issue;
   logic                      ready;

   assign issue = (state == DIV_ISS_IDLE) && is_div_op(aluop_i) && !flush_i;
   assign ready = (div_ready_i == DIV_RESULT_READY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= DIV_ISS_IDLE;
         opdata1     <= ZERO_WORD;
         opdata2     <= ZERO_WORD;
         signed_flag <= 1'b0;
         result      <= '0;
      end else begin
         case (state)
            DIV_ISS_IDLE: begin
               if (issue) begin
                  opdata1     <= reg1_i;
                  opdata2     <= reg2_i;
                  signed_flag <= (aluop_i == EXE_DIV_OP);
                  state       <= DIV_ISS_BUSY;
               end
            end
            // Flush beats a same-cycle ready: the result is simply discarded.
            DIV_ISS_BUSY: begin
               if (flush_i) begin
                  state <= DIV_ISS_IDLE;
               end else if (ready) begin
                  result <= div_result_i;
                  state  <= DIV_ISS_DONE;
               end
            end
            // The divide instruction is still in EX while held; never re-issue it.
            DIV_ISS_DONE: begin
               if (flush_i || !hold_i) begin
                  state <= DIV_ISS_IDLE;
               end
            end
            default: state <= DIV_ISS_IDLE;
         endcase
      end
   end

   assign div_start_o   = (state == DIV_ISS_BUSY) ? DIV_START : DIV_STOP;
   assign div_signed_o  = signed_flag;
   assign div_opdata1_o = opdata1;
   assign div_opdata2_o = opdata2;

   // Combinational terms are gated by rst so every output is 0 during reset.
   assign div_annul_o = !rst && (state == DIV_ISS_BUSY) && flush_i;
   assign stallreq_o  = !rst && (issue || (state == DIV_ISS_BUSY));
   assign whilo_o     = !rst && (state == DIV_ISS_DONE) && !flush_i;

   assign hi_o = (state == DIV_ISS_DONE) ? result[DOUBLE_REG_BUS-1:REG_BUS] : ZERO_WORD;
   assign lo_o = (state == DIV_ISS_DONE) ? result[REG_BUS-1:0]              : ZERO_WORD;

endmodule
`default_nettype wire

// File: tb/tb_div_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_issue : randomized self-checking bench with divider model  rev 1.0 |
// +----------------------------------------------------------------------+
module tb_div_issue;
   import div_issue_pkg::*;

   localparam logic [7:0] NOP_OP = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i;
   logic        flush_i, hold_i;
   logic        div_start_o, div_signed_o, div_annul_o;
   logic [31:0] div_opdata1_o, div_opdata2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        stallreq_o, whilo_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;
   int lat    = 35;
   int cnt;

   div_issue dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .flush_i(flush_i), .hold_i(hold_i), .div_start_o(div_start_o),
      .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o),
      .div_opdata2_o(div_opdata2_o), .div_annul_o(div_annul_o),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i),
      .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   // Architectural divide: {remainder, quotient}, zero divisor gives all zeros.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider stand-in: after lat sampled start cycles, ready pulses for one cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= 0;
         div_ready_i  <= 1'b0;
         div_result_i <= '0;
      end else begin
         div_ready_i <= 1'b0;
         if (!div_start_o || div_annul_o) begin
            cnt <= 0;
         end else begin
            cnt <= cnt + 1;
            if (cnt + 1 == lat) begin
               div_ready_i  <= 1'b1;
               div_result_i <= ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete divide: issue, stall window, HI/LO write held for h extra cycles.
   task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int l, input int h);
      logic [63:0] exp;
      int stall_cnt, busy_ok, busy_cnt, whilo_cnt, held_ok, hold_left;
      logic start_seen;
      exp = ref_div(op == EXE_DIV_OP, a, b);
      lat = l;
      aluop_i = op; reg1_i = a; reg2_i = b;
      #1;
      check_eq("issue_stallreq", {63'd0, stallreq_o}, 64'd1);
      check_eq("issue_start", {63'd0, div_start_o}, 64'd0);
      stall_cnt = 1; busy_ok = 0; busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (whilo_o) break;
         busy_cnt++;
         if (stallreq_o) stall_cnt++;
         if (div_start_o && div_signed_o == (op == EXE_DIV_OP) &&
             div_opdata1_o == a && div_opdata2_o == b) busy_ok++;
      end
      check_eq("stall_window", 64'(stall_cnt), 64'(l + 2));
      check_eq("busy_operands", 64'(busy_ok), 64'(busy_cnt));
      whilo_cnt = 0; held_ok = 0; hold_left = h; start_seen = 1'b0;
      for (int i = 0; i < h + 4 && whilo_o; i++) begin
         if (i == 0) begin
            check_eq("done_hilo", {hi_o, lo_o}, exp);
            check_eq("done_stallreq", {63'd0, stallreq_o}, 64'd0);
         end
         whilo_cnt++;
         if (div_start_o) start_seen = 1'b1;
         if ({hi_o, lo_o} == exp) held_ok++;
         if (hold_left > 0) begin
            hold_i = 1'b1;
            hold_left--;
         end else begin
            hold_i = 1'b0;
            aluop_i = NOP_OP;
         end
         @(negedge clk);
      end
      hold_i = 1'b0; aluop_i = NOP_OP;
      #1;
      check_eq("whilo_len", 64'(whilo_cnt), 64'(h + 1));
      check_eq("held_vals", 64'(held_ok), 64'(h + 1));
      check_eq("no_reissue", {63'd0, start_seen}, 64'd0);
      check_eq("after_idle", {61'd0, div_start_o, stallreq_o, whilo_o}, 64'd0);
   endtask

   // Flush k cycles into BUSY; no HI/LO write may follow.
   task automatic do_flush(input int l, input int k);
      int whilo_seen;
      lat = l;
      aluop_i = EXE_DIVU_OP; reg1_i = 32'd1000; reg2_i = 32'd3;
      for (int i = 0; i < k; i++) @(negedge clk);
      flush_i = 1'b1; aluop_i = NOP_OP;
      #1;
      check_eq("flush_annul", {63'd0, div_annul_o}, 64'd1);
      check_eq("flush_whilo", {63'd0, whilo_o}, 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      check_eq("flush_after", {60'd0, div_start_o, div_annul_o, stallreq_o, whilo_o}, 64'd0);
      whilo_seen = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (whilo_o || div_start_o) whilo_seen++;
      end
      check_eq("flush_quiet", 64'(whilo_seen), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [7:0]  op;
      rst = 1'b1; aluop_i = EXE_DIV_OP; reg1_i = 32'd12; reg2_i = 32'd5;
      flush_i = 1'b0; hold_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_outs", {div_start_o, div_signed_o, div_annul_o, stallreq_o, whilo_o,
                              div_opdata1_o, hi_o, lo_o}, 64'd0);
      aluop_i = NOP_OP;
      rst = 1'b0;
      @(negedge clk);

      do_div(EXE_DIVU_OP, 32'd100, 32'd7, 35, 0);
      do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 35, 0);
      do_div(EXE_DIVU_OP, 32'd5, 32'd0, 2, 0);
      do_flush(35, 10);
      do_div(EXE_DIVU_OP, 32'd9, 32'd3, 35, 0);
      do_flush(9, 10);
      do_div(EXE_DIV_OP, 32'd77, 32'hFFFF_FFF5, 35, 3);

      for (int n = 0; n < 8; n++) begin
         op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
         a  = $urandom;
         b  = (n % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         if (op == EXE_DIV_OP && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         do_div(op, a, b, $urandom_range(1, 40), $urandom_range(0, 2));
      end

      // Asynchronous reset in the middle of a divide.
      lat = 35;
      aluop_i = EXE_DIV_OP; reg1_i = 32'd500; reg2_i = 32'd9;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_busy_outs", {div_start_o, div_signed_o, div_annul_o, stallreq_o, whilo_o,
                                 div_opdata1_o, div_opdata2_o}, 64'd0);
      aluop_i = NOP_OP;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_release", {62'd0, div_start_o, stallreq_o}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
